// File: rtl/cmd_stream_loader.sv
// ---------------------------------------------------------------------------
// cmd_stream_loader
//
// Parses a TRS-80 /CMD object stream arriving on the HPS ioctl bus and writes
// the load-module bytes into system RAM through a request/acknowledge port.
// While a RAM write is outstanding the ioctl stream is held off with
// ioctl_wait. Transfer-address records (type 02) capture execute_addr; any
// other record type (headers, comments, ...) is skipped by its length byte.
//
// Optional feature: define CMD_LOADER_RANGE_CHECK_EN to suppress writes whose
// address falls outside [RAM_LO, RAM_HI] and flag them with error_code = 3.
//
// Handshake: mem_wr is a request held high, with mem_addr/mem_data stable,
// until the cycle in which mem_ack is sampled high; the write is complete at
// that edge and mem_wr drops in the following cycle. ioctl_wait mirrors
// mem_wr; any ioctl_wr seen while ioctl_wait is high is dropped (overrun).
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   ioctl_download      download active (session framing)
//   ioctl_index         menu index, must equal INDEX to start a session
//   ioctl_wr/ioctl_dout one-cycle byte strobe and stream byte
//   ioctl_wait          hold the stream while a RAM write is outstanding
//   mem_wr/mem_ack      RAM write request / acceptance
//   mem_addr/mem_data   RAM write address / data
//   loader_download     high while a session is being parsed
//   execute_addr        captured transfer address
//   execute_enable      one-cycle pulse when execute_addr is captured
//   done                one-cycle pulse at session end
//   error_code          sticky: 0 none, 1 truncated, 2 overrun, 3 range
//   dbg_state_o         current parser state (debug)
// ---------------------------------------------------------------------------
module cmd_stream_loader #(
    parameter int unsigned     DATA   = 8,
    parameter int unsigned     ADDR   = 16,
    parameter logic [7:0]      INDEX  = 8'd2,
    parameter logic [ADDR-1:0] RAM_LO = ADDR'(16'h4000),
    parameter logic [ADDR-1:0] RAM_HI = ADDR'(16'hFFFF)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ioctl_download,
    input  logic [7:0]      ioctl_index,
    input  logic            ioctl_wr,
    input  logic [DATA-1:0] ioctl_dout,
    output logic            ioctl_wait,
    output logic            mem_wr,
    input  logic            mem_ack,
    output logic [ADDR-1:0] mem_addr,
    output logic [DATA-1:0] mem_data,
    output logic            loader_download,
    output logic [ADDR-1:0] execute_addr,
    output logic            execute_enable,
    output logic            done,
    output logic [1:0]      error_code,
    output logic [3:0]      dbg_state_o
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_GET_TYPE = 4'd1,
        S_GET_LEN  = 4'd2,
        S_GET_LSB  = 4'd3,
        S_GET_MSB  = 4'd4,
        S_DATA     = 4'd5,
        S_WAIT_ACK = 4'd6,
        S_SKIP     = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_TRUNC = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_RANGE = 2'd3;

    state_t          state_q;
    logic            dl_prev_q;
    logic [7:0]      type_q;
    logic [7:0]      lsb_q;
    logic [8:0]      cnt_q;       // bytes left in the current record body
    logic            end_pend_q;  // download ended while a write was pending
    logic            mem_wr_q;
    logic            wait_q;
    logic [ADDR-1:0] mem_addr_q;
    logic [DATA-1:0] mem_data_q;
    logic            loader_q;
    logic [ADDR-1:0] exec_addr_q;
    logic            exec_en_q;
    logic            done_q;
    logic [1:0]      err_q;

    logic [7:0] byte_d;
    logic       dl_rise_d;
    logic       dl_fall_d;
    logic [8:0] len_data_d;
    logic [8:0] len_exec_d;
    logic [8:0] len_skip_d;
    logic       in_window_d;
    logic       in_range_d;

    assign byte_d    = ioctl_dout[7:0];
    assign dl_rise_d = ioctl_download && !dl_prev_q && (ioctl_index == INDEX);
    assign dl_fall_d = !ioctl_download && dl_prev_q;

    // Type 01: the length byte includes the two address bytes, and a result
    // of 0 (L = 2) means a full 256-byte body; L = 0/1 wrap to 254/255.
    assign len_data_d = (byte_d == 8'd2) ? 9'd256 : {1'b0, byte_d - 8'd2};
    // Type 02: whatever follows the two address bytes is discarded.
    assign len_exec_d = (byte_d < 8'd2) ? 9'd0 : {1'b0, byte_d - 8'd2};
    // Other types: the whole body is skipped; L = 0 means 256.
    assign len_skip_d = (byte_d == 8'd0) ? 9'd256 : {1'b0, byte_d};

    // Compared one bit wider so a full-range window is not a constant compare.
    assign in_window_d = ({1'b0, mem_addr_q} >= {1'b0, RAM_LO}) &&
                         ({1'b0, mem_addr_q} <= {1'b0, RAM_HI});

`ifdef CMD_LOADER_RANGE_CHECK_EN
    assign in_range_d = in_window_d;
`else
    // Window is ignored in this build; every data byte is written.
    logic unused_window;
    assign unused_window = in_window_d;
    assign in_range_d    = 1'b1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dl_prev_q   <= 1'b0;
            type_q      <= 8'd0;
            lsb_q       <= 8'd0;
            cnt_q       <= 9'd0;
            end_pend_q  <= 1'b0;
            mem_wr_q    <= 1'b0;
            wait_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            loader_q    <= 1'b0;
            exec_addr_q <= '0;
            exec_en_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ERR_NONE;
        end else begin
            dl_prev_q <= ioctl_download;
            exec_en_q <= 1'b0;
            done_q    <= 1'b0;

            // A byte offered while the stream is held is lost.
            if (ioctl_wr && wait_q && (err_q == ERR_NONE)) begin
                err_q <= ERR_OVER;
            end

            case (state_q)
                S_IDLE: begin
                    if (dl_rise_d) begin
                        loader_q   <= 1'b1;
                        err_q      <= ERR_NONE;
                        end_pend_q <= 1'b0;
                        state_q    <= S_GET_TYPE;
                    end
                end

                S_WAIT_ACK: begin
                    if (dl_fall_d) begin
                        end_pend_q <= 1'b1;
                        if (err_q == ERR_NONE) begin
                            err_q <= ERR_TRUNC;
                        end
                    end
                    if (mem_ack) begin
                        mem_wr_q   <= 1'b0;
                        wait_q     <= 1'b0;
                        mem_addr_q <= mem_addr_q + 1'b1;
                        cnt_q      <= cnt_q - 9'd1;
                        // Truncated session: finish only once the write lands.
                        if (dl_fall_d || end_pend_q) begin
                            done_q     <= 1'b1;
                            loader_q   <= 1'b0;
                            end_pend_q <= 1'b0;
                            state_q    <= S_IDLE;
                        end else if (cnt_q == 9'd1) begin
                            state_q <= S_GET_TYPE;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end

                default: begin
                    if (dl_fall_d) begin
                        // Ending between records (or after a transfer
                        // address) is clean; anywhere else is truncation.
                        if ((state_q != S_GET_TYPE) && (state_q != S_DONE) &&
                            (err_q == ERR_NONE)) begin
                            err_q <= ERR_TRUNC;
                        end
                        done_q   <= 1'b1;
                        loader_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (ioctl_wr) begin
                        case (state_q)
                            S_GET_TYPE: begin
                                type_q  <= byte_d;
                                state_q <= S_GET_LEN;
                            end
                            S_GET_LEN: begin
                                if (type_q == 8'h01) begin
                                    cnt_q   <= len_data_d;
                                    state_q <= S_GET_LSB;
                                end else if (type_q == 8'h02) begin
                                    cnt_q   <= len_exec_d;
                                    state_q <= S_GET_LSB;
                                end else begin
                                    cnt_q   <= len_skip_d;
                                    state_q <= S_SKIP;
                                end
                            end
                            S_GET_LSB: begin
                                lsb_q   <= byte_d;
                                state_q <= S_GET_MSB;
                            end
                            S_GET_MSB: begin
                                if (type_q == 8'h01) begin
                                    mem_addr_q <= ADDR'({byte_d, lsb_q});
                                    state_q    <= S_DATA;
                                end else begin
                                    exec_addr_q <= ADDR'({byte_d, lsb_q});
                                    exec_en_q   <= 1'b1;
                                    state_q     <= (cnt_q == 9'd0) ? S_DONE : S_SKIP;
                                end
                            end
                            S_DATA: begin
                                if (in_range_d) begin
                                    mem_data_q <= ioctl_dout;
                                    mem_wr_q   <= 1'b1;
                                    wait_q     <= 1'b1;
                                    state_q    <= S_WAIT_ACK;
                                end else begin
                                    // Out-of-window byte: consumed but not written.
                                    mem_addr_q <= mem_addr_q + 1'b1;
                                    cnt_q      <= cnt_q - 9'd1;
                                    if (err_q == ERR_NONE) begin
                                        err_q <= ERR_RANGE;
                                    end
                                    state_q <= (cnt_q == 9'd1) ? S_GET_TYPE : S_DATA;
                                end
                            end
                            S_SKIP: begin
                                cnt_q <= cnt_q - 9'd1;
                                if (cnt_q == 9'd1) begin
                                    state_q <= (type_q == 8'h02) ? S_DONE : S_GET_TYPE;
                                end
                            end
                            default: begin
                                // S_DONE: trailing bytes are ignored.
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign ioctl_wait      = wait_q;
    assign mem_wr          = mem_wr_q;
    assign mem_addr        = mem_addr_q;
    assign mem_data        = mem_data_q;
    assign loader_download = loader_q;
    assign execute_addr    = exec_addr_q;
    assign execute_enable  = exec_en_q;
    assign done            = done_q;
    assign error_code      = err_q;
    assign dbg_state_o     = state_q;

endmodule
